cdb_grant_controller: RTL and testbench

CDB_GRANT_CONTROLLER -- requirements
Module: cdb_grant_controller

---
 rtl/pkg_defines.sv | 16 +
 rtl/cdb_grant_controller_if.sv | 29 ++
 rtl/rr_pick.sv | 45 ++++
 rtl/cdb_grant_controller.sv | 83 ++++++++
 tb/tb_cdb_grant_controller.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/pkg_defines.sv
// Shared constants and helpers for the CDB grant controller.
// Lane select width is fixed at 8 bits; NUM_REQ must stay below 255.
package pkg_defines;

  localparam int          SEL_W       = 8;
  localparam logic [7:0]  IDLE_SEL    = 8'hFF;
  localparam int          DEF_NUM_BUS = 2;

  function automatic logic [7:0] ptr_inc(
    input logic [7:0] idx,
    input int         n
  );
    return (idx == 8'(n - 1)) ? 8'd0 : idx + 8'd1;
  endfunction

endpackage

// File: rtl/cdb_grant_controller_if.sv
// Bundle between the grant register stage and the round-robin picker.
// Master owns request/pointer, slave returns the per-lane winners.
interface cdb_grant_controller_if
  import pkg_defines::*;
#(
  parameter int NUM_REQ = 8,
  parameter int NUM_BUS = DEF_NUM_BUS
);

  logic [NUM_REQ-1:0]            req;
  logic [7:0]                    ptr;
  logic [NUM_BUS-1:0][SEL_W-1:0] win_idx;
  logic [NUM_BUS-1:0]            win_vld;

  modport master (
    output req,
    output ptr,
    input  win_idx,
    input  win_vld
  );

  modport slave (
    input  req,
    input  ptr,
    output win_idx,
    output win_vld
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans from ptr upward with wrap,
// handing the k-th requester found to lane k.
module rr_pick
  import pkg_defines::*;
#(
  parameter int NUM_REQ = 8,
  parameter int NUM_BUS = DEF_NUM_BUS
) (
  cdb_grant_controller_if.slave pk
);

  logic [8:0] pos;
  logic       hit;
  logic [7:0] cnt;

  always_comb begin
    pk.win_idx = {NUM_BUS{IDLE_SEL}};
    pk.win_vld = '0;
    pos        = '0;
    hit        = 1'b0;
    cnt        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, pk.ptr} + 9'(k);
      if (pos >= 9'(NUM_REQ)) begin
        pos = pos - 9'(NUM_REQ);
      end
      hit = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pos == 9'(i)) begin
          hit = pk.req[i];
        end
      end
      if (hit) begin
        for (int l = 0; l < NUM_BUS; l++) begin
          if (cnt == 8'(l)) begin
            pk.win_idx[l] = pos[7:0];
            pk.win_vld[l] = 1'b1;
          end
        end
        cnt = cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/cdb_grant_controller.sv
// CDB lane grant controller: registers round-robin winners one cycle
// after the request is sampled; flush beats stall beats requests.
module cdb_grant_controller
  import pkg_defines::*;
#(
  parameter int NUM_REQ = 8,
  parameter int NUM_BUS = DEF_NUM_BUS
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic [NUM_REQ-1:0]            i_request,
  input  logic                          i_stall,
  input  logic                          i_flush,
  output logic [NUM_REQ-1:0]            o_bus_granted,
  output logic [NUM_BUS-1:0][SEL_W-1:0] o_select,
  output logic [NUM_BUS-1:0]            o_lane_valid
);

  logic [7:0]                    ptr_q, ptr_d;
  logic [NUM_BUS-1:0][SEL_W-1:0] sel_q, sel_d;
  logic [NUM_BUS-1:0]            vld_q, vld_d;
  logic [NUM_REQ-1:0]            gnt_q, gnt_d;

  cdb_grant_controller_if #(
    .NUM_REQ (NUM_REQ),
    .NUM_BUS (NUM_BUS)
  ) pk_if ();

  assign pk_if.req = i_request;
  assign pk_if.ptr = ptr_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .NUM_BUS (NUM_BUS)
  ) u_pick (
    .pk (pk_if.slave)
  );

  always_comb begin
    sel_d = {NUM_BUS{IDLE_SEL}};
    vld_d = '0;
    gnt_d = '0;
    ptr_d = ptr_q;
    if (i_flush) begin
      ptr_d = '0;
    end else if (!i_stall) begin
      // later lanes overwrite ptr_d, so it ends past the last winner
      for (int l = 0; l < NUM_BUS; l++) begin
        if (pk_if.win_vld[l]) begin
          sel_d[l] = pk_if.win_idx[l];
          vld_d[l] = 1'b1;
          ptr_d    = ptr_inc(pk_if.win_idx[l], NUM_REQ);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int l = 0; l < NUM_BUS; l++) begin
          if (vld_d[l] && sel_d[l] == 8'(i)) begin
            gnt_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr_q <= '0;
      sel_q <= {NUM_BUS{IDLE_SEL}};
      vld_q <= '0;
      gnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      vld_q <= vld_d;
      gnt_q <= gnt_d;
    end
  end

  assign o_bus_granted = gnt_q;
  assign o_select      = sel_q;
  assign o_lane_valid  = vld_q;

endmodule

// File: tb/tb_cdb_grant_controller.sv
// Bench for cdb_grant_controller: directed literal cases plus random
// traffic compared every cycle against a modulo-arithmetic model.
module tb_cdb_grant_controller;

  localparam int NR = 8;
  localparam int NB = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req;
  logic                   stall;
  logic                   flush;
  logic [NR-1:0]          gnt;
  logic [NB-1:0][7:0]     sel;
  logic [NB-1:0]          vld;

  always #5 clk = ~clk;

  cdb_grant_controller #(
    .NUM_REQ (NR),
    .NUM_BUS (NB)
  ) dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_request     (req),
    .i_stall       (stall),
    .i_flush       (flush),
    .o_bus_granted (gnt),
    .o_select      (sel),
    .o_lane_valid  (vld)
  );

  cdb_grant_controller_if #(.NUM_REQ(NR), .NUM_BUS(NB)) pif ();
  rr_pick #(.NUM_REQ(NR), .NUM_BUS(NB)) u_ref_pick (.pk(pif));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [NR-1:0]      e_gnt;
  logic [NB-1:0][7:0] e_sel;
  logic [NB-1:0]      e_vld;
  int                 m_ptr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_pick(
    input  logic [NR-1:0]      r,
    input  int                 p,
    output logic [NB-1:0][7:0] s,
    output logic [NB-1:0]      v,
    output logic [NR-1:0]      g,
    output int                 nxt
  );
    int n;
    int idx;
    n   = 0;
    s   = '1;
    v   = '0;
    g   = '0;
    nxt = p;
    for (int k = 0; k < NR; k++) begin
      idx = (p + k) % NR;
      if (r[idx] && n < NB) begin
        s[n]   = 8'(idx);
        v[n]   = 1'b1;
        g[idx] = 1'b1;
        nxt    = (idx + 1) % NR;
        n++;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int nxt;
    if (!rst_n || flush) begin
      e_sel = '1;
      e_vld = '0;
      e_gnt = '0;
      m_ptr = 0;
    end else if (stall) begin
      e_sel = '1;
      e_vld = '0;
      e_gnt = '0;
    end else begin
      ref_pick(req, m_ptr, e_sel, e_vld, e_gnt, nxt);
      m_ptr = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_gnt", 32'(gnt), 32'(e_gnt));
      chk("cyc_sel", 32'(sel), 32'(e_sel));
      chk("cyc_vld", 32'(vld), 32'(e_vld));
      chk("cyc_ptr", 32'(dut.ptr_q), 32'(m_ptr));
    end
  end

  task automatic do_reset();
    req = '0; stall = 1'b0; flush = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [15:0] pairs [5];
  logic [NB-1:0][7:0] ps;
  logic [NB-1:0]      pv;
  logic [NR-1:0]      pg;
  int                 pn;

  initial begin
    pairs = '{16'h0100, 16'h0302, 16'h0504, 16'h0706, 16'h0100};
    rst_n = 1'b0; req = '0; stall = 1'b0; flush = 1'b0;
    pif.req = '0; pif.ptr = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_sel", 32'(sel), 32'hFFFF);
    chk("rst_ptr", 32'(dut.ptr_q), 32'h0);
    chk_en = 1'b1;
    #1 rst_n = 1'b1;

    req = 8'b0000_0101;
    @(negedge clk);
    chk("two_sel", 32'(sel), 32'h0200);
    chk("two_gnt", 32'(gnt), 32'h05);
    chk("two_ptr", 32'(dut.ptr_q), 32'd3);

    do_reset();
    req = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("all_sel", 32'(sel), 32'(pairs[c]));
      chk("all_vld", 32'(vld), 32'h3);
    end

    req = 8'b0100_0000;
    @(negedge clk);
    chk("to7_ptr", 32'(dut.ptr_q), 32'd7);
    req = 8'b1000_0010;
    @(negedge clk);
    chk("wrap_sel", 32'(sel), 32'h0107);
    chk("wrap_gnt", 32'(gnt), 32'h82);
    chk("wrap_ptr", 32'(dut.ptr_q), 32'd2);

    req = 8'b0001_0000;
    @(negedge clk);
    chk("one_sel", 32'(sel), 32'hFF04);
    chk("one_vld", 32'(vld), 32'h1);
    chk("one_gnt", 32'(gnt), 32'h10);

    req = 8'hFF;
    @(negedge clk);
    chk("pre_sel", 32'(sel), 32'h0605);
    stall = 1'b1;
    @(negedge clk);
    chk("stall_vld", 32'(vld), 32'h0);
    chk("stall_gnt", 32'(gnt), 32'h0);
    chk("stall_ptr", 32'(dut.ptr_q), 32'd7);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_sel", 32'(sel), 32'hFFFF);
    chk("flush_vld", 32'(vld), 32'h0);
    chk("flush_ptr", 32'(dut.ptr_q), 32'd0);
    flush = 1'b0; stall = 1'b0;

    @(negedge clk);
    chk("arst_pre", 32'(vld), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(vld), 32'h0);
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_sel", 32'(sel), 32'hFFFF);
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      req   = ($urandom_range(0, 1) == 0) ? NR'($urandom)
                                          : NR'($urandom & $urandom);
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    chk_en = 1'b0;

    for (int n = 0; n < 40; n++) begin
      pif.req = NR'($urandom);
      pif.ptr = 8'($urandom_range(0, NR - 1));
      #1;
      ref_pick(pif.req, int'(pif.ptr), ps, pv, pg, pn);
      chk("pick_idx", 32'(pif.win_idx), 32'(ps));
      chk("pick_vld", 32'(pif.win_vld), 32'(pv));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
